// File: rtl/riscv_pkg.sv
// Shared RV64 EX-stage definitions: M-extension multiply op codes, the
// iterative multiplier state encoding and its fixed latency.
package riscv_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam int MUL_LATENCY = 69;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_MUL    = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NEG_HI = 3'd5,
        ST_DONE   = 3'd6
    } mul_state_e;

    // Request attributes captured when a multiply is accepted.
    typedef struct packed {
        logic [1:0] op;
        logic       sa;
        logic       sb;
        logic       neg;
    } mul_req_t;

endpackage

// File: rtl/adder64.sv
// Shared 64-bit ripple/carry adder used by the EX-stage iterative units.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        ovfl
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    assign ovfl        = (a[63] == b[63]) && (sum[63] != a[63]);
endmodule

// File: rtl/seq_mul64.sv
// Iterative RV64M multiplier: sign-magnitude shift-add, one bit per cycle,
// with all negations and accumulation sharing a single adder64.
module seq_mul64
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    mul_state_e      state, state_nxt;
    mul_req_t        req, req_d;
    logic [XLEN-1:0] a_q, b_q, ma, hi, lo;
    logic [CNT_W-1:0] cnt;
    logic            carry_q;

    logic [XLEN-1:0] add_a, add_b, add_sum;
    logic            add_cin, add_cout, unused_ovfl;

    adder64 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovfl (unused_ovfl)
    );

    always_comb begin
        req_d     = '0;
        req_d.op  = op;
        req_d.sa  = (op != MUL_OP_MULHU) & a[XLEN-1];
        req_d.sb  = ((op == MUL_OP_MUL) | (op == MUL_OP_MULH)) & b[XLEN-1];
        req_d.neg = req_d.sa ^ req_d.sb;
    end

    // Adder operand mux: two's-complement negation is ~x + cin in every NEG state.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            ST_NEG_A:  begin add_a = ~a_q; add_cin = 1'b1; end
            ST_NEG_B:  begin add_a = ~b_q; add_cin = 1'b1; end
            ST_MUL:    begin add_a = hi;   add_b = lo[0] ? ma : '0; end
            ST_NEG_LO: begin add_a = ~lo;  add_cin = 1'b1; end
            ST_NEG_HI: begin add_a = ~hi;  add_cin = carry_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_NEG_A;
            ST_NEG_A:  state_nxt = ST_NEG_B;
            ST_NEG_B:  state_nxt = ST_MUL;
            ST_MUL:    if (cnt == CNT_W'(XLEN-1)) state_nxt = ST_NEG_LO;
            ST_NEG_LO: state_nxt = ST_NEG_HI;
            ST_NEG_HI: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ma      <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    req <= req_d;
                    a_q <= a;
                    b_q <= b;
                end
                ST_NEG_A: ma <= req.sa ? add_sum : a_q;
                ST_NEG_B: begin
                    lo  <= req.sb ? add_sum : b_q;
                    hi  <= '0;
                    cnt <= '0;
                end
                // {cout,sum,lo} shifted right by one: the product grows into hi.
                ST_MUL: begin
                    hi  <= {add_cout, add_sum[XLEN-1:1]};
                    lo  <= {add_sum[0], lo[XLEN-1:1]};
                    cnt <= cnt + 1'b1;
                end
                ST_NEG_LO: begin
                    if (req.neg) lo <= add_sum;
                    carry_q <= req.neg & add_cout;
                end
                ST_NEG_HI: begin
                    if (req.neg) hi <= add_sum;
                    if (req.op == MUL_OP_MUL) result <= lo;
                    else                      result <= req.neg ? add_sum : hi;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_mul64.md
Name: seq_mul64

Overview:
- Iterative RV64M multiplier for the EX stage; implements MUL, MULH, MULHSU and MULHU.
- Feeds operands into one shared adder64 instance and consumes its sum/cout every cycle.
- Uses shift-add, one multiplier bit per cycle; sign handling is done by negation passes through the same adder.
- Fixed latency of 69 cycles, with a start/busy/done handshake toward the pipeline control.

Parameters:
- XLEN, 64, operand/result width. Only 64 is supported, to match adder64.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- a  input  64  rs1 operand
- b  input  64  rs2 operand
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse; result is valid in this cycle
- result  output  64  MUL → low 64 bits of the product; MULH* → high 64 bits

Behaviour:
- Reset: the reset_n low edge asynchronously clears busy=0, done=0, result=0, state=IDLE and all internal registers. Reset mid-operation aborts the operation; nothing is retained.
- Signedness by op:
  - a is signed for MUL, MULH and MULHSU.
  - b is signed for MUL and MULH.
  - Internal flags: sa = signed_a & a[63]; sb = signed_b & b[63]; neg = sa ^ sb.
- Start acceptance: in IDLE with start=1, latch a, b, op, sa, sb, neg → NEG_A. In any other state, start is ignored and operand changes have no effect.
- NEG_A (1 cycle): if sa, ma ← adder64(~a, 0, cin=1); else ma ← a.
- NEG_B (1 cycle): same rule applied to b into the low product half (lo). Set hi ← 0 and cnt ← 0.
- MUL (64 cycles):
  - adder64 inputs: hi and (lo[0] ? ma : 0), cin=0.
  - Update: {hi,lo} ← {cout, sum, lo[63:1]} >> 0, i.e. the 129-bit value {cout,sum,lo} shifted right by 1.
  - cnt increments each cycle; leave MUL when cnt = 63.
- NEG_LO (1 cycle): if neg, lo ← adder64(~lo, 0, cin=1) and the cout is registered as borrow. Else lo and hi are unchanged, and the registered carry is 0.
- NEG_HI (1 cycle): if neg, hi ← adder64(~hi, 0, cin=registered carry).
- DONE (1 cycle):
  - done=1, busy=1.
  - result is registered from lo (MUL) or hi (others) on entry to DONE.
  - Then → IDLE.
- result holds its value in IDLE until the next DONE.
- Latency: start sampled at edge 0 → done high in cycle 69. Every op takes the same path and latency; states are never skipped.
- Magnitude −2^63 → 2^63 is representable unsigned, so no overflow is possible. The 64×64 magnitude product fits in 128 bits.
- Zero product with neg=1: the negation yields 0 (~0+1 = 0, cout=1 propagates into ~0 → 0). No special case is needed.
- The adder64 cin and inputs are muxed by state. The ovfl output is unused.
- Back-to-back operation: start can be accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Shared package (riscv_pkg) holds:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU (2 bits)
  - state encoding for IDLE, NEG_A, NEG_B, MUL, NEG_LO, NEG_HI, DONE (3 bits)
  - MUL_LATENCY = 69
- Sub-modules: only the existing adder64, instanced once. The operand/cin mux and FSM stay inline; no new sub-module.

Test Plan:
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MUL with the same operands → 0x0000_0000_0000_0001.
- MUL a=−3 (0xFFFF_FFFF_FFFF_FFFD), b=7 → 0xFFFF_FFFF_FFFF_FFEB. MULH with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- MULH a=b=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000. MULHSU with the same operands → 0xC000_0000_0000_0000.
- MULHSU a=0xFFFF_FFFF_FFFF_FFFF (−1), b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF. MULH a=0, b=−5 → 0.
- Handshake with start at edge 0:
  - busy=1 for cycles 1–69; done=1 only in cycle 69.
  - Pulsing start and changing a/b/op in cycles 5 and 40 has no effect.
  - A second start in cycle 70 completes in cycle 139.
- Assert reset_n=0 asynchronously in cycle 30 of a MULHU → busy, done and result read 0 before the next clk edge. After release, a new MUL 6×7 gives 42 (0x2A) in cycle 69 after its start.
